memo_recorder: RTL
==================

# memo_recorder

Trains the memoization table from misses. On a lookup miss at a memoizable function entry, it latches the call key (entry PC, key hash, return address) and watches the retire stream until control returns to that address. It accumulates the final a0/a1 values written by the function, then offers a fill entry to the memo table over a valid/ready handshake. Functions with side effects, or that run too long, are aborted and never filled. It sits between the core's retire/lookup signals and the memo table's fill port.

## Interface
- `XLEN`, default 32: register and PC width.
- `HASH_W`, default 32: key hash width, taken unchanged from the lookup stage.
- `MAX_CYCLES`, default 4096: tracking timeout in cycles, ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `memo_enable`  in  1  global enable; low forces abort or idle.
- `lk_valid`  in  1  a memo lookup was performed this cycle.
- `lk_miss`  in  1  the lookup missed; qualified by `lk_valid`.
- `lk_pc`  in  XLEN  function entry PC.
- `lk_hash`  in  HASH_W  key hash of (ra, a0, a1).
- `lk_ra`  in  XLEN  return address (value of x1).
- `ret_valid`  in  1  one instruction retired this cycle.
- `ret_next_pc`  in  XLEN  PC following the retired instruction.
- `ret_rd_we`, `ret_rd`, `ret_rd_val`  in  1/5/XLEN  architectural register write of the retired instruction.
- `ret_side_effect`  in  1  the retired instruction is a store, CSR, fence, ecall or ebreak.
- `fill_valid`  out  1  fill entry offered.
- `fill_ready`  in  1  memo table accepts the fill.
- `fill_pc`, `fill_hash`, `fill_ret_pc`  out  XLEN/HASH_W/XLEN  entry key and resume PC.
- `fill_a0`, `fill_a1`  out  XLEN  recorded output values.
- `fill_wmask`  out  2  bit0 means a0 was written; bit1 means a1 was written.
- `busy`  out  1  state is not IDLE.
- `dbg_commit_count`, `dbg_abort_count`  out  32  statistics.

## Operation
- States: IDLE, TRACK, FILL.
- **IDLE → TRACK:** on `memo_enable & lk_valid & lk_miss`.
  - Latch `lk_pc`, `lk_hash`, and `lk_ra` into the captured return address (cap_ra).
  - Clear `fill_wmask`, the output values, and the cycle counter.
- **In TRACK, retire-stream rules:** each retire with `ret_valid` and `ret_rd_we` is examined.
  - `ret_rd`==10 stores `ret_rd_val` into a0 and sets wmask[0].
  - `ret_rd`==11 stores `ret_rd_val` into a1 and sets wmask[1].
  - rd==0 and all other registers are ignored.
  - A later write overwrites an earlier one.
- **TRACK → FILL:** on `ret_valid & ret_next_pc==cap_ra`. The register write of that returning instruction is included in the entry.
- **TRACK → IDLE (abort):** any of the following, with `dbg_abort_count` incremented:
  - `ret_side_effect` on a valid retire;
  - the cycle counter reaches MAX_CYCLES−1;
  - `memo_enable` is low.
- **Abort priority:** abort wins over return detection in the same cycle.
- **FILL → IDLE:** on `fill_valid & fill_ready`. `dbg_commit_count` increments on the same edge.
  - `fill_*` outputs hold stable while valid and not ready.
  - `memo_enable` falling in FILL does not cancel the fill; the table decides.
- **No nesting:** lookups arriving in TRACK or FILL are ignored and not queued. This includes a miss in the same cycle as a TRACK→FILL or FILL→IDLE transition.
- **Reserved values:** wmask==0 is legal and fills a no-output entry.
- **Counter widths:** the timeout counter is $clog2(MAX_CYCLES) bits, minimum 1, and saturates. Statistics counters wrap modulo 2^32.

## Timing
- **Reset values:** state IDLE; `fill_valid`=0, `busy`=0; all `fill_*` buses, `fill_wmask`, and both counters are 0.
- **Capture latency:** a miss at edge-cycle N gives `busy`=1 from cycle N+1. Retires in cycle N are not tracked.
- **Fill latency:** a return retire in cycle M gives `fill_valid`=1 in cycle M+1.
- **Minimum path:** miss in N, return in N+1, fill offered in N+2; accepted in N+2 if ready, then IDLE in N+3.
- **Reset mid-operation:** `rst_n` low asynchronously returns to IDLE. The pending entry is dropped and nothing is counted.

## Configuration
- Macro: `MEMO_REC_STATS_EN`.
- **Defined:** `dbg_commit_count` and `dbg_abort_count` are implemented as described.
- **Undefined:** no counter flops exist; both outputs are tied to 0. All other behaviour is identical.

## Test plan
- **Basic fill:**
  - Stimulus: miss with pc=0x1000, hash=0x2005, ra=0x2000; then retires writing a0=12; then retire with next_pc=0x2000; `fill_ready`=1.
  - Response: `fill_valid` one cycle after the return, carrying pc=0x1000, a0=12, wmask=01, ret_pc=0x2000; commit_count=1.
- **Two outputs with backpressure:**
  - Stimulus: miss with pc=0x3000, ra=0x4000; writes a1=5 then a1=77, a0=42; return; `fill_ready` low for 3 cycles.
  - Response: outputs hold a0=42, a1=77, wmask=11 stable through the stall; accepted on the 4th cycle.
- **Side-effect abort:** a store retires in TRACK → IDLE next cycle, `fill_valid` never asserts, abort_count=1.
- **Timeout:** with MAX_CYCLES=8 and no return → abort after 8 cycles in TRACK, `busy` drops.
- **Ignored miss and simultaneous abort:** a second miss during TRACK is ignored (captured pc unchanged). A return and a side-effect in the same retire → abort, no fill.
- **Reset mid-FILL:** `rst_n` low while `fill_valid`=1 → all outputs 0 immediately; a following miss is captured normally.

Source files
------------

// File: rtl/memo_recorder_if.sv
// Lookup, retire and fill-port signals of the memo recorder.
// master: recorder view (drives the fill offer); slave: core/table view.
interface memo_recorder_if #(
  parameter int XLEN   = 32,
  parameter int HASH_W = 32
);
  logic              lk_valid;
  logic              lk_miss;
  logic [XLEN-1:0]   lk_pc;
  logic [HASH_W-1:0] lk_hash;
  logic [XLEN-1:0]   lk_ra;

  logic              ret_valid;
  logic [XLEN-1:0]   ret_next_pc;
  logic              ret_rd_we;
  logic [4:0]        ret_rd;
  logic [XLEN-1:0]   ret_rd_val;
  logic              ret_side_effect;

  logic              fill_valid;
  logic              fill_ready;
  logic [XLEN-1:0]   fill_pc;
  logic [HASH_W-1:0] fill_hash;
  logic [XLEN-1:0]   fill_ret_pc;
  logic [XLEN-1:0]   fill_a0;
  logic [XLEN-1:0]   fill_a1;
  logic [1:0]        fill_wmask;

  modport master (
    input  lk_valid, lk_miss, lk_pc, lk_hash, lk_ra,
    input  ret_valid, ret_next_pc, ret_rd_we, ret_rd, ret_rd_val, ret_side_effect,
    input  fill_ready,
    output fill_valid, fill_pc, fill_hash, fill_ret_pc, fill_a0, fill_a1, fill_wmask
  );

  modport slave (
    output lk_valid, lk_miss, lk_pc, lk_hash, lk_ra,
    output ret_valid, ret_next_pc, ret_rd_we, ret_rd, ret_rd_val, ret_side_effect,
    output fill_ready,
    input  fill_valid, fill_pc, fill_hash, fill_ret_pc, fill_a0, fill_a1, fill_wmask
  );
endinterface

// File: rtl/memo_recorder.sv
// Records a0/a1 results of a missed memoizable call and offers them as a memo-table fill.
// Define MEMO_REC_STATS_EN to implement dbg_commit_count/dbg_abort_count; otherwise they read 0.
module memo_recorder #(
  parameter int XLEN       = 32,
  parameter int HASH_W     = 32,
  parameter int MAX_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 memo_enable,
  memo_recorder_if.master      bus,
  output logic                 busy,
  output logic [31:0]          dbg_commit_count,
  output logic [31:0]          dbg_abort_count
);
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FILL} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [XLEN-1:0]   ra_q, ra_d;
  logic [XLEN-1:0]   a0_q, a0_d;
  logic [XLEN-1:0]   a1_q, a1_d;
  logic [1:0]        wmask_q, wmask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      hash_q  <= '0;
      ra_q    <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hash_q  <= hash_d;
      ra_q    <= ra_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hash_d         = hash_q;
    ra_d           = ra_q;
    a0_d           = a0_q;
    a1_d           = a1_q;
    wmask_d        = wmask_q;
    cnt_d          = cnt_q;
    abort          = 1'b0;
    bus.fill_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memo_enable && bus.lk_valid && bus.lk_miss) begin
          state_d = S_TRACK;
          pc_d    = bus.lk_pc;
          hash_d  = bus.lk_hash;
          ra_d    = bus.lk_ra;
          a0_d    = '0;
          a1_d    = '0;
          wmask_d = '0;
          cnt_d   = '0;
        end
      end
      S_TRACK: begin
        // Abort is evaluated first so it takes precedence over a same-cycle return.
        abort = !memo_enable || (bus.ret_valid && bus.ret_side_effect) || (cnt_q == CNT_LAST);
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (bus.ret_valid && bus.ret_rd_we) begin
            if (bus.ret_rd == 5'd10) begin
              a0_d       = bus.ret_rd_val;
              wmask_d[0] = 1'b1;
            end
            if (bus.ret_rd == 5'd11) begin
              a1_d       = bus.ret_rd_val;
              wmask_d[1] = 1'b1;
            end
          end
          if (bus.ret_valid && (bus.ret_next_pc == ra_q)) state_d = S_FILL;
        end
      end
      S_FILL: begin
        bus.fill_valid = 1'b1;
        if (bus.fill_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy            = (state_q != S_IDLE);
  assign bus.fill_pc     = pc_q;
  assign bus.fill_hash   = hash_q;
  assign bus.fill_ret_pc = ra_q;
  assign bus.fill_a0     = a0_q;
  assign bus.fill_a1     = a1_q;
  assign bus.fill_wmask  = wmask_q;

`ifdef MEMO_REC_STATS_EN
  logic [31:0] commit_q, abort_cnt_q;
  logic        commit_inc, abort_inc;

  assign commit_inc = (state_q == S_FILL) && bus.fill_ready;
  assign abort_inc  = (state_q == S_TRACK) && abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q    <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (commit_inc) commit_q    <= commit_q + 32'd1;
      if (abort_inc)  abort_cnt_q <= abort_cnt_q + 32'd1;
    end
  end

  assign dbg_commit_count = commit_q;
  assign dbg_abort_count  = abort_cnt_q;
`else
  assign dbg_commit_count = '0;
  assign dbg_abort_count  = '0;
`endif
endmodule
